// File: rtl/rng_address_requester_if.sv
// Handshake bundle between the rng address requester (master) and the rng address responder (slave).
`timescale 1ns/1ps
interface rng_address_requester_if;
   logic        rng_nreset;
   logic        start_rng_address;
   logic [15:0] which;
   logic [15:0] count;
   logic [15:0] rng_address;
   logic        done_rng_address;

   modport master (
      output rng_nreset, start_rng_address, which, count,
      input  rng_address, done_rng_address
   );

   modport slave (
      input  rng_nreset, start_rng_address, which, count,
      output rng_address, done_rng_address
   );
endinterface

// File: rtl/rng_address_requester.sv
// Requests a random neighbour address: steps an LFSR, re-arms and launches the responder,
// waits for its result (with timeout) and returns it as a one-cycle strobe.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  IDLE   | waiting for start; seed loads honoured here
//  ARM    | responder held in reset for ARM_CYCLES cycles
//  LAUNCH | one-cycle start_rng_address pulse
//  WAIT   | waiting for done_rng_address or timeout
//  DONE   | issue done/error/selected_index, then back to IDLE
`timescale 1ns/1ps
module rng_address_requester #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          ARM_CYCLES = 2,
   parameter int          TIMEOUT    = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [15:0]                   betterNeighborCount,
   input  logic                          seed_load,
   input  logic [15:0]                   seed_value,
   rng_address_requester_if.master       rsp,
   output logic [15:0]                   selected_index,
   output logic                          done,
   output logic                          error,
   output logic                          busy
);

   localparam int AW = $clog2(ARM_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, ARM, LAUNCH, WAIT, DONE} state_t;

   state_t        state;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_next;
   logic [AW-1:0] arm_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   captured;
   logic          err_pend;

   assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   always_ff @(posedge clock) begin
      if (reset) begin
         state                 <= IDLE;
         lfsr                  <= LFSR_SEED;
         arm_cnt               <= '0;
         tmo_cnt               <= '0;
         captured              <= '0;
         err_pend              <= 1'b0;
         rsp.rng_nreset        <= 1'b0;
         rsp.start_rng_address <= 1'b0;
         rsp.which             <= '0;
         rsp.count             <= '0;
         selected_index        <= '0;
         done                  <= 1'b0;
         error                 <= 1'b0;
         busy                  <= 1'b0;
      end else begin
         done                  <= 1'b0;
         error                 <= 1'b0;
         rsp.start_rng_address <= 1'b0;
         case (state)
            IDLE: begin
               rsp.rng_nreset <= 1'b1;
               if (start) begin
                  lfsr      <= lfsr_next;
                  rsp.which <= lfsr_next;
                  rsp.count <= betterNeighborCount;
                  busy      <= 1'b1;
                  // a zero modulus would never terminate in the responder, so never launch it
                  if (betterNeighborCount == 16'd0) begin
                     err_pend <= 1'b1;
                     state    <= DONE;
                  end else begin
                     err_pend       <= 1'b0;
                     rsp.rng_nreset <= 1'b0;
                     arm_cnt        <= ARM_LOAD;
                     state          <= ARM;
                  end
               end else if (seed_load) begin
                  lfsr <= (seed_value == 16'd0) ? LFSR_SEED : seed_value;
               end
            end
            ARM: begin
               if (arm_cnt == '0) begin
                  rsp.rng_nreset        <= 1'b1;
                  rsp.start_rng_address <= 1'b1;
                  state                 <= LAUNCH;
               end else begin
                  arm_cnt <= arm_cnt - 1'b1;
               end
            end
            LAUNCH: begin
               tmo_cnt <= TMO_LOAD;
               state   <= WAIT;
            end
            WAIT: begin
               if (rsp.done_rng_address) begin
                  captured <= rsp.rng_address;
                  state    <= DONE;
               end else if (tmo_cnt == '0) begin
                  err_pend <= 1'b1;
                  state    <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt - 1'b1;
               end
            end
            DONE: begin
               done           <= 1'b1;
               error          <= err_pend;
               selected_index <= err_pend ? 16'd0 : captured;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rng_address_requester.sv
// Randomized bench for rng_address_requester with a behavioural responder and request-level reference model.
`timescale 1ns/1ps
module tb_rng_address_requester;
   localparam int          ARM  = 2;
   localparam int          TMO  = 1024;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] nbc;
   logic        seed_load;
   logic [15:0] seed_value;
   logic [15:0] selected_index;
   logic        done;
   logic        error;
   logic        busy;

   rng_address_requester_if rsp_bus();

   rng_address_requester #(.LFSR_SEED(SEED), .ARM_CYCLES(ARM), .TIMEOUT(TMO)) dut (
      .clock               (clock),
      .reset               (reset),
      .start               (start),
      .betterNeighborCount (nbc),
      .seed_load           (seed_load),
      .seed_value          (seed_value),
      .rsp                 (rsp_bus.master),
      .selected_index      (selected_index),
      .done                (done),
      .error               (error),
      .busy                (busy)
   );

   always #5 clock = ~clock;

   // responder stand-in: answers which % count after rsp_delay cycles, sticky until reset
   int   rsp_delay  = 1;
   logic never_done = 1'b0;
   logic r_pend;
   int   r_cnt;
   always @(posedge clock) begin
      if (!rsp_bus.rng_nreset) begin
         rsp_bus.done_rng_address <= 1'b0;
         rsp_bus.rng_address      <= 16'd0;
         r_pend                   <= 1'b0;
         r_cnt                    <= 0;
      end else if (rsp_bus.start_rng_address) begin
         r_pend <= !never_done;
         r_cnt  <= rsp_delay - 1;
      end else if (r_pend) begin
         if (r_cnt == 0) begin
            rsp_bus.done_rng_address <= 1'b1;
            rsp_bus.rng_address      <= (rsp_bus.count == 16'd0) ? 16'd0 : rsp_bus.which % rsp_bus.count;
            r_pend                   <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1;
         end
      end
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_lfsr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   // One request from a negedge in IDLE; returns at the negedge where done is seen.
   task automatic do_req(input logic [15:0] cnt, input int dly, input logic nev,
                         input logic seed_with_start, input logic seed_busy,
                         output logic [15:0] got_which);
      logic [15:0] exp_which;
      logic [15:0] exp_sel;
      int exp_e, e, low, pulses, which_bad, busy_bad;
      logic seen;
      rsp_delay  = dly;
      never_done = nev;
      exp_which  = lfsr_step(m_lfsr);
      m_lfsr     = exp_which;
      if (cnt == 16'd0)  exp_e = 1;
      else if (nev)      exp_e = ARM + TMO + 2;
      else               exp_e = ARM + dly + 3;
      exp_sel = (cnt == 16'd0 || nev) ? 16'd0 : exp_which % cnt;

      start      = 1'b1;
      nbc        = cnt;
      seed_load  = seed_with_start;
      seed_value = 16'($urandom);
      @(posedge clock);
      #1;
      start     = 1'b0;
      nbc       = 16'($urandom);
      seed_load = seed_busy;
      e = 0; low = 0; pulses = 0; which_bad = 0; busy_bad = 0; seen = 1'b0;
      while (e < 3000) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (!rsp_bus.rng_nreset) low++;
         if (rsp_bus.start_rng_address) pulses++;
         if (rsp_bus.which !== exp_which) which_bad++;
         if (busy !== 1'b1) busy_bad++;
         @(posedge clock);
         e++;
      end
      seed_load = 1'b0;
      got_which = rsp_bus.which;
      check("done_seen", {31'd0, seen}, 32'd1);
      check("latency", e, exp_e);
      check("which", {16'd0, rsp_bus.which}, {16'd0, exp_which});
      check("which_stable", which_bad, 0);
      check("busy_while_active", busy_bad, 0);
      check("count_to_rsp", {16'd0, rsp_bus.count}, {16'd0, cnt});
      check("selected_index", {16'd0, selected_index}, {16'd0, exp_sel});
      check("error", {31'd0, error}, {31'd0, (cnt == 16'd0) || nev});
      check("nreset_low_cycles", low, (cnt == 16'd0) ? 0 : ARM);
      check("launch_pulses", pulses, (cnt == 16'd0) ? 0 : 1);
      check("busy_at_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic idle_gap();
      @(posedge clock);
      @(negedge clock);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("error_cleared", {31'd0, error}, 32'd0);
   endtask

   task automatic idle_seed(input logic [15:0] v);
      seed_load  = 1'b1;
      seed_value = v;
      @(posedge clock);
      m_lfsr = (v == 16'd0) ? SEED : v;
      @(negedge clock);
      seed_load = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      logic        seen_pulse;
      int          k;
      reset = 1'b1; start = 1'b0; nbc = 16'd0; seed_load = 1'b0; seed_value = 16'd0;
      m_lfsr = SEED;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_nreset", {31'd0, rsp_bus.rng_nreset}, 32'd0);
      check("rst_start_rng", {31'd0, rsp_bus.start_rng_address}, 32'd0);
      check("rst_which", {16'd0, rsp_bus.which}, 32'd0);
      check("rst_sel", {16'd0, selected_index}, 32'd0);
      check("rst_done_err_busy", {29'd0, done, error, busy}, 32'd0);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("idle_nreset", {31'd0, rsp_bus.rng_nreset}, 32'd1);

      // 1: count 5, responder answers after 4 cycles
      do_req(16'd5, 4, 1'b0, 1'b0, 1'b0, w);
      check("t1_which", {16'd0, w}, 32'h0000E270);
      check("t1_sel", {16'd0, selected_index}, 32'd3);
      // 2: back-to-back with a stale done_rng_address still high
      check("t2_stale_high", {31'd0, rsp_bus.done_rng_address}, 32'd1);
      do_req(16'd9, 6, 1'b0, 1'b0, 1'b0, w);
      check("t2_which", {16'd0, w}, 32'h00007138);
      idle_gap();
      // 3: zero count
      do_req(16'd0, 3, 1'b0, 1'b0, 1'b0, w);
      idle_gap();
      // 4: responder never completes
      do_req(16'd17, 1, 1'b1, 1'b0, 1'b0, w);
      idle_gap();
      check("t4_busy_after", {31'd0, busy}, 32'd0);
      // 5: zero seed maps to default; seed_load while busy ignored
      idle_seed(16'd0);
      do_req(16'd5, 2, 1'b0, 1'b0, 1'b1, w);
      check("t5_which", {16'd0, w}, 32'h0000E270);
      idle_gap();
      do_req(16'd5, 2, 1'b0, 1'b0, 1'b0, w);
      check("t5_busy_seed_ignored", {16'd0, w}, 32'h00007138);
      idle_gap();
      idle_seed(16'h0001);
      do_req(16'd100, 3, 1'b0, 1'b1, 1'b0, w);
      check("t5_seed_one", {16'd0, w}, 32'h0000B400);
      idle_gap();

      // 6: reset while waiting on the responder
      rsp_delay = 40; never_done = 1'b0;
      start = 1'b1; nbc = 16'd7;
      @(posedge clock);
      #1 start = 1'b0;
      seen_pulse = 1'b0;
      k = 0;
      while (!seen_pulse && k < 50) begin
         @(negedge clock);
         if (rsp_bus.start_rng_address) seen_pulse = 1'b1;
         k++;
      end
      check("t6_launched", {31'd0, seen_pulse}, 32'd1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("t6_nreset", {31'd0, rsp_bus.rng_nreset}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_no_done", {31'd0, done}, 32'd0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      m_lfsr = SEED;
      @(posedge clock);
      @(negedge clock);
      check("t6_no_done_after", {30'd0, done, busy}, 32'd0);
      do_req(16'd5, 4, 1'b0, 1'b0, 1'b0, w);
      check("t6_which", {16'd0, w}, 32'h0000E270);
      idle_gap();

      // randomized requests
      for (int i = 0; i < 30; i++) begin
         logic [15:0] c;
         c = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 60000));
         if ($urandom_range(0, 2) == 0) idle_seed(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
         do_req(c, int'($urandom_range(1, 10)), 1'b0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), w);
         if ($urandom_range(0, 1) == 0) idle_gap();
      end
      idle_gap();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
